// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   ADDR_W_DEF  : default byte-address width (64-byte memory)
//   DATA_W_DEF  : default word width (big-endian 16-bit words)
//   NUM_PORTS   : number of requesters
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_PORTS  = 2;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-requester round-robin selector.
//   req[1:0] : active requests
//   last     : port granted most recently
//   winner   : selected port (meaningful only when valid=1)
//   valid    : at least one request is present
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    // A single requester wins outright; on a tie the port that was not
    // granted last goes next.
    winner = req[1];
    if (req == 2'b11) begin
      winner = ~last;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a shared byte-addressed memory.
// Each access takes three cycles: IDLE (request sampled), ACCESS (grant
// pulse, memory strobe), RESP (done/err pulse, read data already captured).
//   clock, reset                 : clock, async active-high reset
//   req/we/addr/wdata 0 and 1    : requester inputs, held until grant
//   gnt/done/err/rdata 0 and 1   : per-port handshake pulses and read word
//   mem_addr/mem_wdata           : latched access address and write word
//   mem_read/mem_write           : one-cycle strobes during ACCESS
//   mem_rdata                    : combinational read word from the memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              done0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  output logic              gnt1,
  output logic              done1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t              state_reg;
  logic                    last_reg;
  logic                    port_reg;
  logic                    we_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic                    mem_read_reg;
  logic                    mem_write_reg;
  logic [NUM_PORTS-1:0]    gnt_reg;
  logic [NUM_PORTS-1:0]    done_reg;
  logic [NUM_PORTS-1:0]    err_reg;
  logic [DATA_W-1:0]       rdata_reg [NUM_PORTS];

  logic                    pick_winner;
  logic                    pick_valid;
  logic                    sel_we;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;

  rr_pick2 u_pick (
    .req    ({req1, req0}),
    .last   (last_reg),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign sel_we    = pick_winner ? we1    : we0;
  assign sel_addr  = pick_winner ? addr1  : addr0;
  assign sel_wdata = pick_winner ? wdata1 : wdata0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      port_reg      <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      err_reg       <= '0;
      rdata_reg[0]  <= '0;
      rdata_reg[1]  <= '0;
    end else begin
      // All handshake outputs and memory strobes are single-cycle pulses.
      gnt_reg       <= '0;
      done_reg      <= '0;
      err_reg       <= '0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg              <= ACCESS;
            last_reg               <= pick_winner;
            port_reg               <= pick_winner;
            we_reg                 <= sel_we;
            addr_reg               <= sel_addr;
            wdata_reg              <= sel_wdata;
            gnt_reg[pick_winner]   <= 1'b1;
            // Odd addresses are misaligned: the memory is never strobed.
            mem_read_reg           <= ~sel_we & ~sel_addr[0];
            mem_write_reg          <= sel_we & ~sel_addr[0];
          end
        end
        ACCESS: begin
          state_reg          <= RESP;
          done_reg[port_reg] <= 1'b1;
          err_reg[port_reg]  <= addr_reg[0];
          if (!we_reg && !addr_reg[0]) begin
            rdata_reg[port_reg] <= mem_rdata;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign gnt0      = gnt_reg[0];
  assign gnt1      = gnt_reg[1];
  assign done0     = done_reg[0];
  assign done1     = done_reg[1];
  assign err0      = err_reg[0];
  assign err1      = err_reg[1];
  assign rdata0    = rdata_reg[0];
  assign rdata1    = rdata_reg[1];
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;

endmodule
